// File: rtl/wb_trace_recorder.sv
// rtl/wb_trace_recorder.sv - dual-lane writeback trace capture with ordered record FIFO
module wb_trace_recorder #(
  parameter int          DEPTH  = 16,
  parameter logic [31:0] END_PC = 32'hbfc00100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        open_trace,
  input  logic        wb0_en,
  input  logic        wb1_en,
  input  logic [4:0]  wb0_rd,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb0_wdata,
  input  logic [31:0] wb1_wdata,
  input  logic [31:0] wb0_pc,
  input  logic [31:0] wb1_pc,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic        trace_flag,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_wdata,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic [31:0] rec_count,
  output logic        trace_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 70;

  // Record layout: {flag, pc, rd, wdata}
  logic [REC_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [REC_W-1:0] rec0;
  logic [REC_W-1:0] rec1;
  logic [REC_W-1:0] head;

  logic             cand0;
  logic             cand1;
  logic             end0;
  logic             end1;
  logic             want0;
  logic             want1;
  logic             push0;
  logic             push1;
  logic             drop0;
  logic             drop1;
  logic             pop;
  logic [1:0]       n_push;
  logic [1:0]       n_drop;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] lane1_slot;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  assign rec0 = {open_trace, wb0_pc, wb0_rd, wb0_wdata};
  assign rec1 = {open_trace, wb1_pc, wb1_rd, wb1_wdata};

  // Candidate selection, END_PC cut and space allocation for this cycle
  always_comb begin
    cand0       = capture_en && !trace_done && wb0_en;
    cand1       = capture_en && !trace_done && wb1_en;
    end0        = cand0 && (wb0_pc == END_PC);
    end1        = cand1 && (wb1_pc == END_PC);
    // Hitting END_PC on the older lane also suppresses the younger lane
    want0       = cand0 && !end0;
    want1       = cand1 && !end0 && !end1;
    // Free space is taken from count before this cycle's pop on purpose:
    // a same-cycle drain never makes room for a same-cycle push.
    free_slots  = CNT_W'(DEPTH) - count;
    push0       = want0 && (free_slots != '0);
    push1       = want1 && (free_slots > CNT_W'(push0));
    drop0       = want0 && !push0;
    drop1       = want1 && !push1;
    n_push      = {1'b0, push0} + {1'b0, push1};
    n_drop      = {1'b0, drop0} + {1'b0, drop1};
    pop         = trace_valid && trace_ready;
    count_next  = count + CNT_W'(n_push) - CNT_W'(pop);
    wr_ptr_next = wr_ptr + PTR_W'(n_push);
    // A lone lane-1 push takes the slot lane 0 would have used
    lane1_slot  = push0 ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    drop_sum    = {1'b0, drop_count} + 17'(n_drop);
    drop_next   = drop_sum[16] ? 16'hffff : drop_sum[15:0];
  end

  // Record storage; contents need no reset because count masks stale entries
  always_ff @(posedge clock) begin
    if (push0) begin
      mem[wr_ptr] <= rec0;
    end
    if (push1) begin
      mem[lane1_slot] <= rec1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count_next;
    end
  end

  // Sticky status flags and statistics counters
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      rec_count  <= '0;
      trace_done <= 1'b0;
    end else begin
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
      end
      if (end0 || end1) begin
        trace_done <= 1'b1;
      end
      drop_count <= drop_next;
      rec_count  <= rec_count + 32'(n_push);
    end
  end

  // Head presentation driven only from registered state; reads zero when empty
  always_comb begin
    trace_valid = (count != '0);
    head        = trace_valid ? mem[rd_ptr] : '0;
    trace_flag  = head[69];
    trace_pc    = head[68:37];
    trace_rd    = head[36:32];
    trace_wdata = head[31:0];
  end

endmodule

// File: tb/tb_wb_trace_recorder.sv
// tb/tb_wb_trace_recorder.sv - directed self-checking bench for wb_trace_recorder
module tb_wb_trace_recorder;

  logic        clock;
  logic        reset;
  logic        capture_en;
  logic        open_trace;
  logic        wb0_en;
  logic        wb1_en;
  logic [4:0]  wb0_rd;
  logic [4:0]  wb1_rd;
  logic [31:0] wb0_wdata;
  logic [31:0] wb1_wdata;
  logic [31:0] wb0_pc;
  logic [31:0] wb1_pc;
  logic        trace_valid;
  logic        trace_ready;
  logic        trace_flag;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_wdata;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] rec_count;
  logic        trace_done;

  int compared;
  int mismatched;

  wb_trace_recorder #(.DEPTH(16), .END_PC(32'hbfc00100)) dut (
    .clock       (clock),
    .reset       (reset),
    .capture_en  (capture_en),
    .open_trace  (open_trace),
    .wb0_en      (wb0_en),
    .wb1_en      (wb1_en),
    .wb0_rd      (wb0_rd),
    .wb1_rd      (wb1_rd),
    .wb0_wdata   (wb0_wdata),
    .wb1_wdata   (wb1_wdata),
    .wb0_pc      (wb0_pc),
    .wb1_pc      (wb1_pc),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_flag  (trace_flag),
    .trace_pc    (trace_pc),
    .trace_rd    (trace_rd),
    .trace_wdata (trace_wdata),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .rec_count   (rec_count),
    .trace_done  (trace_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic lanes_off();
    wb0_en = 1'b0;
    wb1_en = 1'b0;
  endtask

  task automatic set_lane0(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
    wb0_en    = 1'b1;
    wb0_pc    = pc;
    wb0_rd    = rd;
    wb0_wdata = wd;
  endtask

  task automatic set_lane1(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
    wb1_en    = 1'b1;
    wb1_pc    = pc;
    wb1_rd    = rd;
    wb1_wdata = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] last_pc;

    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    capture_en  = 1'b1;
    open_trace  = 1'b0;
    trace_ready = 1'b0;
    wb0_en = 1'b0; wb0_pc = '0; wb0_rd = '0; wb0_wdata = '0;
    wb1_en = 1'b0; wb1_pc = '0; wb1_rd = '0; wb1_wdata = '0;
    cycle();
    cycle();
    reset = 1'b0;

    check("rst_valid", 64'(trace_valid), 64'd0);
    check("rst_pc",    64'(trace_pc),    64'd0);
    check("rst_rd",    64'(trace_rd),    64'd0);
    check("rst_wdata", 64'(trace_wdata), 64'd0);
    check("rst_flag",  64'(trace_flag),  64'd0);
    check("rst_ovf",   64'(overflow),    64'd0);
    check("rst_drop",  64'(drop_count),  64'd0);
    check("rst_rec",   64'(rec_count),   64'd0);
    check("rst_done",  64'(trace_done),  64'd0);

    // Ordering: lane 0 first, then lane 1 on the next cycle
    trace_ready = 1'b1;
    set_lane0(32'hbfc00000, 5'd2, 32'h11);
    set_lane1(32'hbfc00004, 5'd3, 32'h22);
    cycle();
    lanes_off();
    check("ord_valid0", 64'(trace_valid), 64'd1);
    check("ord_pc0",    64'(trace_pc),    64'hbfc00000);
    check("ord_rd0",    64'(trace_rd),    64'd2);
    check("ord_wd0",    64'(trace_wdata), 64'h11);
    check("ord_rec",    64'(rec_count),   64'd2);
    cycle();
    check("ord_pc1",    64'(trace_pc),    64'hbfc00004);
    check("ord_rd1",    64'(trace_rd),    64'd3);
    check("ord_wd1",    64'(trace_wdata), 64'h22);
    cycle();
    check("ord_empty",  64'(trace_valid), 64'd0);

    // Backpressure: fill 16, then a dual push drops both
    trace_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      set_lane0(32'hbfc00000 + 32'(4 * k), 5'(k + 1), 32'(k));
      cycle();
    end
    lanes_off();
    check("bp_full_valid", 64'(trace_valid), 64'd1);
    check("bp_full_drop",  64'(drop_count),  64'd0);
    check("bp_full_ovf",   64'(overflow),    64'd0);
    set_lane0(32'h1000, 5'd7, 32'h77);
    set_lane1(32'h1004, 5'd8, 32'h88);
    cycle();
    lanes_off();
    check("bp_drop",     64'(drop_count), 64'd2);
    check("bp_ovf",      64'(overflow),   64'd1);
    check("bp_rec",      64'(rec_count),  64'd18);
    check("bp_head_hold", 64'(trace_pc),  64'hbfc00000);
    trace_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("bp_drain_v%0d", k), 64'(trace_valid), 64'd1);
      check($sformatf("bp_drain_pc%0d", k), 64'(trace_pc), 64'(32'hbfc00000 + 32'(4 * k)));
      cycle();
    end
    check("bp_drained", 64'(trace_valid), 64'd0);

    // Pop does not free space: 15 buffered, dual push with pop at the same edge
    trace_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      set_lane0(32'h100 + 32'(4 * k), 5'd1, 32'(k));
      cycle();
    end
    trace_ready = 1'b1;
    set_lane0(32'h200, 5'd9, 32'h99);
    set_lane1(32'h204, 5'd10, 32'haa);
    cycle();
    lanes_off();
    check("pnf_drop", 64'(drop_count), 64'd3);
    check("pnf_rec",  64'(rec_count),  64'd34);
    check("pnf_head", 64'(trace_pc),   64'h104);
    n = 0;
    last_pc = '0;
    while (trace_valid && n < 40) begin
      last_pc = trace_pc;
      n++;
      cycle();
    end
    check("pnf_len",  64'(n),       64'd15);
    check("pnf_last", 64'(last_pc), 64'h200);

    // END_PC on lane 1: only lane 0 recorded, capture stops
    trace_ready = 1'b0;
    set_lane0(32'hbfc000fc, 5'd4, 32'h44);
    set_lane1(32'hbfc00100, 5'd5, 32'h55);
    cycle();
    check("end1_done",  64'(trace_done), 64'd1);
    check("end1_rec",   64'(rec_count),  64'd35);
    check("end1_valid", 64'(trace_valid), 64'd1);
    check("end1_pc",    64'(trace_pc),   64'hbfc000fc);
    set_lane0(32'h600, 5'd6, 32'h66);
    set_lane1(32'h604, 5'd6, 32'h67);
    cycle();
    lanes_off();
    check("end1_after_rec",  64'(rec_count),  64'd35);
    check("end1_after_drop", 64'(drop_count), 64'd3);
    trace_ready = 1'b1;
    cycle();
    check("end1_single", 64'(trace_valid), 64'd0);

    // END_PC on a disabled lane 1 is ignored; END_PC on lane 0 blocks both
    do_reset();
    check("rst2_done", 64'(trace_done), 64'd0);
    trace_ready = 1'b0;
    set_lane0(32'hbfc000fc, 5'd4, 32'h44);
    wb1_pc = 32'hbfc00100;
    wb1_en = 1'b0;
    cycle();
    check("end1off_done",  64'(trace_done),  64'd0);
    check("end1off_rec",   64'(rec_count),   64'd1);
    check("end1off_valid", 64'(trace_valid), 64'd1);
    trace_ready = 1'b1;
    set_lane0(32'hbfc00100, 5'd1, 32'h1);
    set_lane1(32'hbfc00104, 5'd2, 32'h2);
    cycle();
    lanes_off();
    check("end0_done",  64'(trace_done),  64'd1);
    check("end0_rec",   64'(rec_count),   64'd1);
    check("end0_valid", 64'(trace_valid), 64'd0);

    // Lone lane-1 record with rd 0 and flag set; then capture disabled
    do_reset();
    trace_ready = 1'b0;
    open_trace  = 1'b1;
    set_lane1(32'h300, 5'd0, 32'habcd);
    cycle();
    lanes_off();
    check("l1_valid", 64'(trace_valid), 64'd1);
    check("l1_rd",    64'(trace_rd),    64'd0);
    check("l1_flag",  64'(trace_flag),  64'd1);
    check("l1_pc",    64'(trace_pc),    64'h300);
    check("l1_wd",    64'(trace_wdata), 64'habcd);
    check("l1_rec",   64'(rec_count),   64'd1);
    capture_en = 1'b0;
    open_trace = 1'b0;
    set_lane0(32'h310, 5'd1, 32'h1);
    set_lane1(32'h314, 5'd2, 32'h2);
    cycle();
    lanes_off();
    check("cap_off_rec",  64'(rec_count), 64'd1);
    check("cap_off_head", 64'(trace_pc),  64'h300);
    trace_ready = 1'b1;
    cycle();
    check("cap_off_empty", 64'(trace_valid), 64'd0);

    // Reset mid-stream with 5 records buffered and overflow set
    capture_en  = 1'b1;
    trace_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      set_lane0(32'h400 + 32'(8 * k), 5'd1, 32'(k));
      set_lane1(32'h404 + 32'(8 * k), 5'd2, 32'(k));
      cycle();
    end
    lanes_off();
    check("mid_drop", 64'(drop_count), 64'd2);
    trace_ready = 1'b1;
    for (int k = 0; k < 11; k++) cycle();
    trace_ready = 1'b0;
    check("mid_ovf",   64'(overflow),    64'd1);
    check("mid_valid", 64'(trace_valid), 64'd1);
    check("mid_head",  64'(trace_pc),    64'h42c);
    do_reset();
    check("mid_rst_valid", 64'(trace_valid), 64'd0);
    check("mid_rst_pc",    64'(trace_pc),    64'd0);
    check("mid_rst_ovf",   64'(overflow),    64'd0);
    check("mid_rst_drop",  64'(drop_count),  64'd0);
    check("mid_rst_rec",   64'(rec_count),   64'd0);
    set_lane0(32'h500, 5'd3, 32'h55);
    cycle();
    lanes_off();
    check("post_pc",  64'(trace_pc),  64'h500);
    check("post_rec", 64'(rec_count), 64'd1);
    trace_ready = 1'b1;
    cycle();
    check("post_sole", 64'(trace_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_trace_recorder.md
# wb_trace_recorder

Captures the two register-writeback channels of the dual-issue datapath each cycle and emits them as an ordered stream of trace records {flag, pc, rd, wdata}, one record per handshake. It is the producer of the golden-trace format the functional-test bench consumes. It sits beside the writeback stage, in simulation and FPGA debug builds. Records are buffered in a FIFO absorbing two writebacks per cycle against one drain per cycle. Overflow is counted, never silent.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- END_PC, 32'hbfc00100, PC that terminates capture.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- capture_en  in  1  gates all pushes.
- open_trace  in  1  copied into each record's flag at capture.
- wb0_en, wb1_en  in  1 each  lane writes a register; lane 0 is older than lane 1.
- wb0_rd, wb1_rd  in  5 each  destination register.
- wb0_wdata, wb1_wdata  in  32 each  write data.
- wb0_pc, wb1_pc  in  32 each  instruction PC.
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts the head record.
- trace_flag  out  1  head record flag.
- trace_pc  out  32  head record PC.
- trace_rd  out  5  head record destination.
- trace_wdata  out  32  head record data.
- overflow  out  1  sticky; at least one record was dropped for lack of space.
- drop_count  out  16  records dropped for lack of space; saturates at 16'hffff.
- rec_count  out  32  records pushed; wraps modulo 2^32.
- trace_done  out  1  sticky; END_PC seen.

## Operation
Candidates:
- Lane i is a candidate when capture_en is 1, trace_done is 0, and wbi_en is 1.
- END_PC cut: if candidate lane 0 has pc == END_PC, neither lane is pushed and trace_done sets.
- Otherwise, if candidate lane 1 has pc == END_PC, lane 0 (if a candidate) is pushed, lane 1 is not, and trace_done sets.
- A lane whose en is 0 never triggers trace_done, even if its pc equals END_PC.

Push order and space:
- Lane 0 is always pushed before lane 1 in the same cycle.
- A lone lane-1 candidate is pushed as a single entry.
- free = DEPTH − count, sampled before this cycle's pop. A same-cycle pop does not create room for a same-cycle push.
- Candidates are pushed in order while free allows. Each candidate that does not fit increments drop_count and sets overflow.
- Dropped candidates are not counted in rec_count.

Pop and record format:
- A pop occurs when trace_valid and trace_ready are both 1. It removes the head record.
- The trace_* outputs always present the head entry while trace_valid is 1.
- Record fields are a verbatim copy of the lane fields; flag = open_trace at capture.
- rd == 0 records are pushed like any other.

State and reset:
- Storage: DEPTH-entry register array, 70 bits per entry.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is log2(DEPTH)+1 bits, 0..DEPTH.
- Per cycle: count_next = count + pushes − pop, where pushes ∈ {0,1,2} and pop ∈ {0,1}.
- Reset values: count = 0, trace_valid = 0, overflow = 0, drop_count = 0, rec_count = 0, trace_done = 0. trace_pc, trace_rd, trace_wdata and trace_flag read 0.
- Reset mid-stream discards every buffered record in the same edge.
- overflow and trace_done clear only on reset.

## Timing
- Push latency: lanes sampled at edge N are visible on trace_valid/trace_* in the cycle after edge N. There is no combinational input-to-output path.
- trace_valid is a function of registered state only (count != 0).
- Head data must not change while trace_valid = 1 and trace_ready = 0.
- trace_ready may toggle freely. A push and a pop at the same edge are both honoured.
- Throughput: sustained drain of 1 record per cycle.
- Full: count == DEPTH means trace_valid = 1, and any candidate that cycle is dropped.
- Empty with both lanes enabled: two entries are written; trace_valid rises the next cycle.
- Counters (drop_count, rec_count) and trace_done update at the same edge as the corresponding push or drop decision.

## Test plan
- Ordering: DEPTH = 16, trace_ready = 1. One cycle with wb0 = (pc bfc00000, rd 2, wdata 11) and wb1 = (pc bfc00004, rd 3, wdata 22). Two records appear in lane-0-first order on consecutive cycles; rec_count = 2.
- Backpressure: trace_ready = 0. Push 16 single-lane records with pc = bfc00000 + 4k. count reaches 16 with no drops. Next cycle both lanes are enabled: drop_count = 2 and overflow = 1. Then trace_ready = 1 drains exactly 16 records, PCs in order.
- Pop does not free space: count = 15, trace_ready = 1, both lanes enabled. Lane 0 is stored, lane 1 is dropped; count stays 15; drop_count += 1.
- END_PC on lane 1: wb0 pc bfc000fc, wb1 pc bfc00100, both enabled. Only bfc000fc is recorded and trace_done = 1. Later enabled lanes push nothing. Repeat with wb1_en = 0: trace_done stays 0.
- Lane-1-only and flag: wb0_en = 0, wb1_en = 1 with rd 0 and open_trace = 1. One record with rd 0 and flag 1. Then capture_en = 0 with both lanes enabled: no push, rec_count unchanged.
- Reset mid-stream: with 5 records buffered and overflow = 1, assert reset for one cycle. All outputs return to 0 and the next push appears as the sole record.
